// File: rtl/keyboard_scan_sequencer.sv
// Keyboard matrix scan sequencer: row strobe, settle, column sample, valid/ready hand-off.
// Optional ghost detection is compiled in with `define KBD_SCAN_GHOST_DET_EN.
module keyboard_scan_sequencer #(
  parameter int NUM_ROWS = 6,
  parameter int NUM_COLS = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                enable,
  input  logic [7:0]          settle_cycles,
  input  logic [7:0]          gap_cycles,
  output logic [NUM_ROWS-1:0] row_out,
  input  logic [NUM_COLS-1:0] col_in,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [2:0]          sample_row,
  output logic [NUM_COLS-1:0] sample_cols,
  output logic                frame_done,
  output logic [15:0]         frame_cnt,
  output logic [15:0]         stall_cnt,
  output logic                ghost_flag
);
  localparam int ROW_W = 3;

  typedef enum logic [2:0] {S_IDLE, S_DRIVE, S_SAMPLE, S_PUSH, S_GAP} state_t;

  state_t              state, state_nxt;
  logic [ROW_W-1:0]    row;
  logic [8:0]          settle_left;
  logic [7:0]          gap_left;
  logic [NUM_COLS-1:0] sync1, sync2;
  logic                xfer, last_row, take_sample;

  assign xfer        = (state == S_PUSH) && sample_ready;
  assign last_row    = (row == ROW_W'(NUM_ROWS - 1));
  assign take_sample = (state == S_SAMPLE) && enable;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= col_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE:   if (enable) state_nxt = S_DRIVE;
      S_DRIVE:  if (!enable) state_nxt = S_IDLE;
                else if (settle_left == '0) state_nxt = S_SAMPLE;
      S_SAMPLE: state_nxt = enable ? S_PUSH : S_IDLE;
      // a pending sample is never retracted; enable is only honoured once it is accepted
      S_PUSH:   if (sample_ready) begin
                  if (!enable)               state_nxt = S_IDLE;
                  else if (gap_cycles == '0) state_nxt = S_DRIVE;
                  else                       state_nxt = S_GAP;
                end
      S_GAP:    if (!enable) state_nxt = S_IDLE;
                else if (gap_left == '0) state_nxt = S_DRIVE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    row_out      = '0;
    sample_valid = 1'b0;
    if (state == S_DRIVE || state == S_SAMPLE || state == S_PUSH)
      row_out = NUM_ROWS'(1) << row;
    if (state == S_PUSH)
      sample_valid = 1'b1;
  end

  // Timing values are captured on state entry so mid-state edits have no effect.
  always_ff @(posedge clk) begin
    if (rst) begin
      settle_left <= '0;
      gap_left    <= '0;
    end else begin
      if (state_nxt == S_DRIVE && state != S_DRIVE)
        settle_left <= {1'b0, settle_cycles} + 9'd1;
      else if (state == S_DRIVE && settle_left != '0)
        settle_left <= settle_left - 9'd1;
      if (state_nxt == S_GAP && state != S_GAP)
        gap_left <= gap_cycles - 8'd1;
      else if (state == S_GAP && gap_left != '0)
        gap_left <= gap_left - 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                     row <= '0;
    else if (state_nxt == S_IDLE) row <= '0;
    else if (xfer)               row <= last_row ? '0 : row + ROW_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sample_row  <= '0;
      sample_cols <= '0;
      frame_done  <= 1'b0;
      frame_cnt   <= '0;
      stall_cnt   <= '0;
    end else begin
      if (take_sample) begin
        sample_row  <= row;
        sample_cols <= ~sync2;
      end
      frame_done <= xfer && last_row;
      if (xfer && last_row)
        frame_cnt <= frame_cnt + 16'd1;
      if (state == S_PUSH && !sample_ready && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
    end
  end

`ifdef KBD_SCAN_GHOST_DET_EN
  logic [NUM_COLS-1:0] frame_mask [NUM_ROWS];
  logic                ghost_any;

  function automatic logic multi_bit(input logic [NUM_COLS-1:0] m);
    return (m & (m - NUM_COLS'(1))) != '0;
  endfunction

  always_ff @(posedge clk) begin
    if (take_sample)
      frame_mask[row] <= ~sync2;
  end

  always_comb begin
    ghost_any = 1'b0;
    for (int unsigned i = 0; i < NUM_ROWS; i++)
      for (int unsigned j = i + 1; j < NUM_ROWS; j++)
        if (multi_bit(frame_mask[i]) && multi_bit(frame_mask[j]) &&
            ((frame_mask[i] & frame_mask[j]) != '0))
          ghost_any = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst)                   ghost_flag <= 1'b0;
    else if (!enable)          ghost_flag <= 1'b0;
    else if (xfer && last_row) ghost_flag <= ghost_any;
  end
`else
  assign ghost_flag = 1'b0;
`endif

endmodule

// File: tb/tb_keyboard_scan_sequencer.sv
// Randomised bench for keyboard_scan_sequencer against a transaction-level scan model.
module tb_keyboard_scan_sequencer;
  localparam int NUM_ROWS = 6;
  localparam int NUM_COLS = 7;
`ifdef KBD_SCAN_GHOST_DET_EN
  localparam bit GHOST_ON = 1'b1;
`else
  localparam bit GHOST_ON = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst, enable, sample_ready;
  logic [7:0]          settle_cycles, gap_cycles;
  logic [NUM_ROWS-1:0] row_out;
  logic [NUM_COLS-1:0] col_in;
  logic                sample_valid, frame_done, ghost_flag;
  logic [2:0]          sample_row;
  logic [NUM_COLS-1:0] sample_cols;
  logic [15:0]         frame_cnt, stall_cnt;

  keyboard_scan_sequencer #(.NUM_ROWS(NUM_ROWS), .NUM_COLS(NUM_COLS)) dut (
    .clk(clk), .rst(rst), .enable(enable),
    .settle_cycles(settle_cycles), .gap_cycles(gap_cycles),
    .row_out(row_out), .col_in(col_in),
    .sample_valid(sample_valid), .sample_ready(sample_ready),
    .sample_row(sample_row), .sample_cols(sample_cols),
    .frame_done(frame_done), .frame_cnt(frame_cnt), .stall_cnt(stall_cnt),
    .ghost_flag(ghost_flag)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scan model: key matrix, progress through the frame, expected counters
  logic [NUM_COLS-1:0] keys  [NUM_ROWS];
  logic [NUM_COLS-1:0] fmask [NUM_ROWS];
  bit          active, in_push, exp_fd, exp_ghost, en_cmd, rand_keys;
  int          wait_left, gap_m, exp_row, ready_mode;
  logic [15:0] exp_fc, exp_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [NUM_ROWS-1:0] onehot(input int r);
    logic [NUM_ROWS-1:0] v;
    v = '0;
    v[r] = 1'b1;
    return v;
  endfunction

  function automatic bit ghost_ref();
    if (GHOST_ON)
      for (int i = 0; i < NUM_ROWS; i++)
        for (int j = i + 1; j < NUM_ROWS; j++)
          if ($countones(fmask[i]) >= 2 && $countones(fmask[j]) >= 2 &&
              (fmask[i] & fmask[j]) != '0)
            return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [NUM_COLS-1:0] new_key();
    if ($urandom_range(0, 2) == 0) return NUM_COLS'($urandom);
    return '0;
  endfunction

  task automatic model_init();
    active = 0; in_push = 0; exp_fd = 0; exp_ghost = 0;
    wait_left = 0; gap_m = 0; exp_row = 0;
    exp_fc = '0; exp_stall = '0;
  endtask

  // One clock: check outputs on the falling edge, then drive inputs and advance the model.
  task automatic tick();
    bit rdy, xfer;
    logic [NUM_ROWS-1:0] exp_ro;
    @(negedge clk);
    exp_ro = '0;
    if (active && !in_push) begin
      if (wait_left > 0) wait_left--;
      if (wait_left == 0) in_push = 1'b1;
    end
    if (active) begin
      if (gap_m > 0) gap_m--;
      else exp_ro = onehot(exp_row);
    end
    check("valid", sample_valid, in_push);
    check("row_out", row_out, exp_ro);
    if (in_push) begin
      check("sample_row", sample_row, exp_row);
      check("sample_cols", sample_cols, keys[exp_row]);
    end
    check("frame_done", frame_done, exp_fd);
    check("frame_cnt", frame_cnt, exp_fc);
    check("stall_cnt", stall_cnt, exp_stall);
    check("ghost_flag", ghost_flag, exp_ghost);

    case (ready_mode)
      0:       rdy = 1'b0;
      1:       rdy = 1'b1;
      default: rdy = ($urandom_range(0, 9) < 7);
    endcase
    if (!en_cmd) rdy = 1'b1;
    xfer   = in_push && rdy;
    exp_fd = 1'b0;
    if (in_push && !rdy && exp_stall != 16'hFFFF) exp_stall++;
    if (xfer) begin
      fmask[exp_row] = keys[exp_row];
      if (exp_row == NUM_ROWS - 1) begin
        exp_fd    = 1'b1;
        exp_fc    = exp_fc + 16'd1;
        exp_ghost = ghost_ref();
      end
      if (rand_keys) keys[exp_row] = new_key();
      exp_row   = (exp_row + 1) % NUM_ROWS;
      in_push   = 1'b0;
      wait_left = int'(settle_cycles) + int'(gap_cycles) + 4;
      gap_m     = int'(gap_cycles);
    end
    if (!en_cmd) begin
      active = 0; in_push = 0; exp_ghost = 0; gap_m = 0;
    end else if (!active) begin
      active = 1; exp_row = 0; gap_m = 0;
      wait_left = int'(settle_cycles) + 4;
    end
    enable       = en_cmd;
    sample_ready = rdy;
    col_in = NUM_COLS'($urandom);
    for (int r = 0; r < NUM_ROWS; r++)
      if (row_out == onehot(r)) col_in = ~keys[r];
  endtask

  task automatic do_reset();
    en_cmd = 0; enable = 0; sample_ready = 0; rst = 1;
    @(negedge clk);
    @(negedge clk);
    check("rst_row_out", row_out, 0);
    check("rst_valid", sample_valid, 0);
    check("rst_row", sample_row, 0);
    check("rst_cols", sample_cols, 0);
    check("rst_fd", frame_done, 0);
    check("rst_fc", frame_cnt, 0);
    check("rst_stall", stall_cnt, 0);
    check("rst_ghost", ghost_flag, 0);
    model_init();
    rst = 0;
  endtask

  task automatic run_until_fd(input int limit);
    int n = 0;
    do begin tick(); n++; end while (!frame_done && n < limit);
    check("fd_reached", frame_done, 1);
  endtask

  task automatic run_until_push(input int limit);
    int n = 0;
    do begin tick(); n++; end while (!sample_valid && n < limit);
    check("push_reached", sample_valid, 1);
  endtask

  task automatic idle(input int n);
    en_cmd = 0;
    repeat (n) tick();
  endtask

  initial begin
    rst = 1; enable = 0; sample_ready = 0; col_in = '1;
    settle_cycles = 8'd0; gap_cycles = 8'd0;
    en_cmd = 0; rand_keys = 0; ready_mode = 1;
    for (int r = 0; r < NUM_ROWS; r++) begin keys[r] = '0; fmask[r] = '0; end
    model_init();
    do_reset();

    // nominal scan, no keys, three frames
    en_cmd = 1;
    repeat (3) run_until_fd(60);
    check("t1_frame_cnt", frame_cnt, 3);

    // single key at row 2, column 3
    idle(2);
    keys[2] = 7'b0001000;
    en_cmd = 1;
    run_until_fd(60);
    idle(2);
    keys[2] = '0;

    // back-pressure: ready low for 10 clocks in PUSH
    ready_mode = 0; en_cmd = 1;
    run_until_push(30);
    repeat (9) tick();
    ready_mode = 1;
    tick();
    check("t3_stall", stall_cnt, 10);

    // enable drops in DRIVE of row 3, then restart at row 0
    begin
      int n = 0;
      do begin tick(); n++; end while (!(row_out == 6'b001000 && !sample_valid) && n < 60);
      check("t4_row3_seen", row_out, 6'b001000);
    end
    en_cmd = 0;
    tick();
    tick();
    check("t4_row_out_off", row_out, 0);
    en_cmd = 1;
    run_until_push(30);
    check("t4_restart_row", sample_row, 0);

    // longer settle/gap, then frame counter wrap
    idle(2);
    settle_cycles = 8'd5; gap_cycles = 8'd3;
    en_cmd = 1;
    run_until_fd(120);
    idle(2);
    force dut.frame_cnt = 16'hFFFF;
    exp_fc = 16'hFFFF;
    tick();
    release dut.frame_cnt;
    tick();
    en_cmd = 1;
    run_until_fd(120);
    check("t5_wrap", frame_cnt, 0);

    // ghost pattern then a clean frame
    idle(2);
    settle_cycles = 8'd0; gap_cycles = 8'd0;
    keys[0] = 7'b0010100; keys[1] = 7'b0010100;
    en_cmd = 1;
    run_until_fd(60);
    check("t6_ghost_set", ghost_flag, GHOST_ON);
    idle(2);
    keys[0] = '0; keys[1] = '0;
    en_cmd = 1;
    run_until_fd(60);
    check("t6_ghost_clr", ghost_flag, 0);

    // randomised traffic: keys, ready, timing, enable drops
    rand_keys = 1;
    for (int it = 0; it < 14; it++) begin
      int len;
      idle(2);
      settle_cycles = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(20, 40)) : 8'($urandom_range(0, 4));
      gap_cycles    = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(10, 20)) : 8'($urandom_range(0, 4));
      ready_mode = 2; en_cmd = 1;
      len = $urandom_range(150, 400);
      for (int c = 0; c < len; c++) begin
        if ($urandom_range(0, 79) == 0) begin
          en_cmd = 0;
          repeat ($urandom_range(1, 4)) tick();
          en_cmd = 1;
        end
        tick();
      end
    end

    // stall counter saturation
    ready_mode = 1;
    idle(2);
    force dut.stall_cnt = 16'hFFFD;
    exp_stall = 16'hFFFD;
    tick();
    release dut.stall_cnt;
    ready_mode = 0; en_cmd = 1;
    run_until_push(60);
    repeat (4) tick();
    ready_mode = 1;
    tick();
    check("stall_sat", stall_cnt, 16'hFFFF);

    // reset in the middle of a scan
    ready_mode = 2;
    repeat (37) tick();
    do_reset();
    en_cmd = 1; ready_mode = 1;
    run_until_fd(200);
    check("post_rst_fc", frame_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
